mdio_master_mc: RTL and testbench

- Generalised MDIO management master. Supports Clause 22 and Clause 45 frames, a runtime PHY/port address, a parameterised MDC divider and a parameterised preamble length.
- Frame-level valid/ready command and response streams.
- Sits between a management CSR/AXI-Lite bridge and the top-level MDIO tristate pad (mdio_i/mdio_o/mdio_t) for any PHY on the shared bus.
- Adds read-error detection (missing TA zero), which the first-generation master lacks.

---
 rtl/mdio_master_mc.sv | 183 ++++++++++++++++++
 tb/tb_mdio_master_mc.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master_mc.sv
// MDIO master for Clause 22/45 frames. Response is valid 1+(PREAMBLE_LEN+32)*2*HALF_PERIOD cycles after acceptance.
// Only one transaction is in flight: cmd_ready stays low until the response is consumed, and rsp_* hold while rsp_ready is low.
module mdio_master_mc #(
  parameter int HALF_PERIOD  = 62,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_c45,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic        mdc
);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  localparam int               DIV_W    = $clog2(HALF_PERIOD);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);
  localparam logic [5:0]       PRE_BITS = 6'(PREAMBLE_LEN);
  localparam logic [5:0]       TA1_BIT  = 6'(PREAMBLE_LEN + 14);
  localparam logic [5:0]       TA2_BIT  = 6'(PREAMBLE_LEN + 15);
  localparam logic [5:0]       LAST_BIT = 6'(PREAMBLE_LEN + 31);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [5:0]         bit_q, bit_d;
  logic               lead_q, lead_d;
  logic               high_q, high_d;
  logic [31:0]        frame_q, frame_d;
  logic               rd_q, rd_d;
  logic               mdc_q, mdc_d;
  logic               mdio_o_q, mdio_o_d;
  logic               mdio_t_q, mdio_t_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_error_q, rsp_error_d;
  logic [1:0]         sync_q;
  logic               mdio_s;
  logic [5:0]         nxt_bit;
  logic               half_end;

  assign mdio_s = sync_q[1];

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    lead_d      = lead_q;
    high_d      = high_q;
    frame_d     = frame_q;
    rd_d        = rd_q;
    mdc_d       = mdc_q;
    mdio_o_d    = mdio_o_q;
    mdio_t_d    = mdio_t_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    nxt_bit     = lead_q ? 6'd0 : bit_q + 6'd1;
    half_end    = (div_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          state_d     = SHIFT;
          lead_d      = 1'b1;
          frame_d     = {(cmd_c45 ? 2'b00 : 2'b01), cmd_op, cmd_phy_addr, cmd_reg_addr,
                         2'b10, cmd_wdata};
          rd_d        = cmd_c45 ? cmd_op[1] : (cmd_op == 2'b10);
          rsp_rdata_d = '0;
          rsp_error_d = 1'b0;
        end
      end

      SHIFT: begin
        // lead_q marks the one cycle between acceptance and the first bit's low half.
        if (lead_q || (high_q && half_end)) begin
          if (!lead_q && rd_q && (bit_q == TA2_BIT)) rsp_error_d = mdio_s;
          if (!lead_q && rd_q && (bit_q > TA2_BIT)) rsp_rdata_d = {rsp_rdata_q[14:0], mdio_s};
          div_d  = '0;
          high_d = 1'b0;
          mdc_d  = 1'b0;
          if (!lead_q && (bit_q == LAST_BIT)) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            mdio_o_d    = 1'b0;
            mdio_t_d    = 1'b1;
          end else begin
            lead_d   = 1'b0;
            bit_d    = nxt_bit;
            mdio_t_d = 1'b0;
            if (nxt_bit < PRE_BITS) begin
              mdio_o_d = 1'b1;
            end else begin
              mdio_o_d = frame_q[31];
              frame_d  = {frame_q[30:0], 1'b0};
              // Reads hand the bus to the PHY from the first turnaround bit onward.
              if (rd_q && (nxt_bit >= TA1_BIT)) begin
                mdio_o_d = 1'b0;
                mdio_t_d = 1'b1;
              end
            end
          end
        end else if (half_end) begin
          high_d = 1'b1;
          mdc_d  = 1'b1;
          div_d  = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      lead_q      <= 1'b0;
      high_q      <= 1'b0;
      frame_q     <= '0;
      rd_q        <= 1'b0;
      mdc_q       <= 1'b0;
      mdio_o_q    <= 1'b0;
      mdio_t_q    <= 1'b1;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      sync_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      lead_q      <= lead_d;
      high_q      <= high_d;
      frame_q     <= frame_d;
      rd_q        <= rd_d;
      mdc_q       <= mdc_d;
      mdio_o_q    <= mdio_o_d;
      mdio_t_q    <= mdio_t_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      sync_q      <= {sync_q[0], mdio_i};
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_t    = mdio_t_q;
  assign mdc       = mdc_q;

endmodule

// File: tb/tb_mdio_master_mc.sv
// Bench for mdio_master_mc: instance A has a 32-bit preamble, instance B none; both use HALF_PERIOD=4.
// Expected frames, read data and timing come from a queue-based frame model and a small PHY model.
module tb_mdio_master_mc;
  localparam int HP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid_a = 1'b0, cmd_valid_b = 1'b0;
  logic        cmd_c45 = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [4:0]  cmd_phy = 5'h0, cmd_reg = 5'h0;
  logic [15:0] cmd_wdata = 16'h0;
  logic        rsp_ready = 1'b0;
  logic        mdio_i = 1'b1;
  logic        cmd_ready_a, cmd_ready_b, rsp_valid_a, rsp_valid_b, rsp_error_a, rsp_error_b;
  logic [15:0] rsp_rdata_a, rsp_rdata_b;
  logic        mdio_o_a, mdio_o_b, mdio_t_a, mdio_t_b, mdc_a, mdc_b;
  logic        sel = 1'b0;
  logic        s_cmd_ready, s_rsp_valid, s_rsp_error, s_mdio_o, s_mdio_t, s_mdc;
  logic [15:0] s_rsp_rdata;
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  mdio_master_mc #(.HALF_PERIOD(HP), .PREAMBLE_LEN(32)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_c45(cmd_c45), .cmd_op(cmd_op), .cmd_phy_addr(cmd_phy), .cmd_reg_addr(cmd_reg),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_a), .rsp_error(rsp_error_a), .mdio_i(mdio_i),
    .mdio_o(mdio_o_a), .mdio_t(mdio_t_a), .mdc(mdc_a));

  mdio_master_mc #(.HALF_PERIOD(HP), .PREAMBLE_LEN(0)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_c45(cmd_c45), .cmd_op(cmd_op), .cmd_phy_addr(cmd_phy), .cmd_reg_addr(cmd_reg),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_b), .rsp_error(rsp_error_b), .mdio_i(mdio_i),
    .mdio_o(mdio_o_b), .mdio_t(mdio_t_b), .mdc(mdc_b));

  assign s_cmd_ready = sel ? cmd_ready_b : cmd_ready_a;
  assign s_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
  assign s_rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;
  assign s_rsp_error = sel ? rsp_error_b : rsp_error_a;
  assign s_mdio_o    = sel ? mdio_o_b    : mdio_o_a;
  assign s_mdio_t    = sel ? mdio_t_b    : mdio_t_a;
  assign s_mdc       = sel ? mdc_b       : mdc_a;

  // One full transaction on the selected instance, with an optional response stall.
  task automatic do_txn(input logic use_b, input logic c45, input logic [1:0] op,
                        input logic [4:0] phy, input logic [4:0] rega, input logic [15:0] wdata,
                        input logic phy_present, input logic [15:0] phy_data, input int stall);
    int          plen, nbits, waited;
    logic        rd, ok, exp_err;
    logic [31:0] fields;
    logic        exp_o[$], exp_t[$], drv[$];
    logic [15:0] exp_rdata;
    logic [39:0] obs, expv;
    sel    = use_b;
    plen   = use_b ? 0 : 32;
    nbits  = plen + 32;
    rd     = c45 ? op[1] : (op == 2'b10);
    fields = {(c45 ? 2'b00 : 2'b01), op, phy, rega, 2'b10, wdata};
    for (int k = 0; k < plen; k++) begin
      exp_o.push_back(1'b1); exp_t.push_back(1'b0); drv.push_back(1'b1);
    end
    for (int j = 0; j < 32; j++) begin
      if (rd && j >= 14) begin
        exp_o.push_back(1'b0); exp_t.push_back(1'b1);
        if (!phy_present || j == 14) drv.push_back(1'b1);
        else if (j == 15)            drv.push_back(1'b0);
        else                         drv.push_back(phy_data[31-j]);
      end else begin
        exp_o.push_back(fields[31-j]); exp_t.push_back(1'b0); drv.push_back(1'b1);
      end
    end
    exp_rdata = !rd ? 16'h0000 : (phy_present ? phy_data : 16'hFFFF);
    exp_err   = rd && !phy_present;

    @(negedge clk);
    cmd_c45 = c45; cmd_op = op; cmd_phy = phy; cmd_reg = rega; cmd_wdata = wdata;
    if (use_b) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
    waited = 0;
    while (s_cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (s_cmd_ready !== 1'b1) begin
      $display("FAIL accept inst=%0d: cmd_ready=%b after %0d cycles, required 1", use_b, s_cmd_ready, waited);
      cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
      return;
    end
    passes++;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    {cmd_c45, cmd_op, cmd_phy, cmd_reg, cmd_wdata} = 29'($urandom);

    // Per bit, each cycle contributes {mdc, mdio_o (masked when released), mdio_t, rsp_valid, cmd_ready}.
    for (int k = 0; k < nbits; k++) begin
      obs = '0; expv = '0;
      for (int p = 0; p < 2*HP; p++) begin
        @(negedge clk);
        if (p == 0) mdio_i = drv[k];
        obs  = {obs[34:0], s_mdc, (s_mdio_t ? 1'b0 : s_mdio_o), s_mdio_t, s_rsp_valid, s_cmd_ready};
        expv = {expv[34:0], (p >= HP), exp_o[k], exp_t[k], 1'b0, 1'b0};
      end
      checks++;
      if (obs !== expv) $display("FAIL bit%0d inst=%0d: got %h, required %h", k, use_b, obs, expv);
      else passes++;
    end

    @(negedge clk);
    mdio_i = 1'b1;
    checks++;
    if ({s_rsp_valid, s_mdc, s_mdio_t, s_mdio_o} !== 4'b1010)
      $display("FAIL end_of_frame inst=%0d: {valid,mdc,t,o}=%b, required 1010", use_b,
               {s_rsp_valid, s_mdc, s_mdio_t, s_mdio_o});
    else passes++;
    checks++;
    if (s_rsp_rdata !== exp_rdata)
      $display("FAIL rdata inst=%0d: got %h, required %h", use_b, s_rsp_rdata, exp_rdata);
    else passes++;
    checks++;
    if (s_rsp_error !== exp_err)
      $display("FAIL error inst=%0d: got %b, required %b", use_b, s_rsp_error, exp_err);
    else passes++;

    if (stall > 0) begin
      ok = 1'b1;
      if (use_b) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (!(s_rsp_valid === 1'b1 && s_rsp_rdata === exp_rdata && s_rsp_error === exp_err &&
              s_cmd_ready === 1'b0 && s_mdc === 1'b0)) ok = 1'b0;
      end
      checks++;
      if (!ok) $display("FAIL stall inst=%0d: valid=%b rdata=%h err=%b ready=%b mdc=%b, required 1 %h %b 0 0",
                        use_b, s_rsp_valid, s_rsp_rdata, s_rsp_error, s_cmd_ready, s_mdc, exp_rdata, exp_err);
      else passes++;
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    checks++;
    if ({s_cmd_ready, s_rsp_valid} !== 2'b10)
      $display("FAIL release inst=%0d: {cmd_ready,rsp_valid}=%b, required 10", use_b, {s_cmd_ready, s_rsp_valid});
    else passes++;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({mdc_a, mdio_o_a, mdio_t_a, cmd_ready_a, rsp_valid_a, rsp_error_a, rsp_rdata_a} !== {6'b001000, 16'h0})
      $display("FAIL reset_a: got %b_%h, required 001000_0000",
               {mdc_a, mdio_o_a, mdio_t_a, cmd_ready_a, rsp_valid_a, rsp_error_a}, rsp_rdata_a);
    else passes++;
    checks++;
    if ({mdc_b, mdio_o_b, mdio_t_b, cmd_ready_b, rsp_valid_b, rsp_error_b, rsp_rdata_b} !== {6'b001000, 16'h0})
      $display("FAIL reset_b: got %b_%h, required 001000_0000",
               {mdc_b, mdio_o_b, mdio_t_b, cmd_ready_b, rsp_valid_b, rsp_error_b}, rsp_rdata_b);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready_a !== 1'b0) $display("FAIL ready_before_edge: got %b, required 0", cmd_ready_a);
    else passes++;
    @(negedge clk);
    checks++;
    if ({cmd_ready_a, cmd_ready_b} !== 2'b11)
      $display("FAIL ready_after_edge: got %b, required 11", {cmd_ready_a, cmd_ready_b});
    else passes++;
  endtask

  task automatic test_c22_write();
    do_txn(1'b0, 1'b0, 2'b01, 5'h0C, 5'h00, 16'h1140, 1'b1, 16'h0000, 0);
  endtask

  task automatic test_c22_read();
    do_txn(1'b0, 1'b0, 2'b10, 5'h01, 5'h02, 16'h0000, 1'b1, 16'h2000, 0);
  endtask

  task automatic test_c22_read_nophy();
    do_txn(1'b0, 1'b0, 2'b10, 5'h01, 5'h02, 16'h0000, 1'b0, 16'h0000, 0);
  endtask

  task automatic test_c45();
    do_txn(1'b0, 1'b1, 2'b00, 5'h03, 5'h01, 16'h0007, 1'b1, 16'h0000, 0);
    do_txn(1'b0, 1'b1, 2'b11, 5'h03, 5'h01, 16'h0000, 1'b1, 16'hBEEF, 0);
    do_txn(1'b1, 1'b1, 2'b00, 5'h03, 5'h01, 16'h0007, 1'b1, 16'h0000, 0);
    do_txn(1'b1, 1'b1, 2'b11, 5'h03, 5'h01, 16'h0000, 1'b1, 16'hBEEF, 0);
  endtask

  task automatic test_back_to_back();
    do_txn(1'b0, 1'b0, 2'b10, 5'h07, 5'h03, 16'h0000, 1'b1, 16'h5A3C, 100);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      do_txn(1'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
             16'($urandom), 1'($urandom), 16'($urandom), int'($urandom_range(0, 4)));
  endtask

  task automatic test_reset_midframe();
    int waited;
    sel = 1'b0;
    @(negedge clk);
    cmd_c45 = 1'b0; cmd_op = 2'b01; cmd_phy = 5'h05; cmd_reg = 5'h09; cmd_wdata = 16'hA5C3;
    cmd_valid_a = 1'b1;
    waited = 0;
    while (cmd_ready_a !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid_a = 1'b0;
    // Land in the high half of data bit 10 (frame bit 58).
    repeat (1 + 58*2*HP + HP + 1) @(negedge clk);
    checks++;
    if (mdc_a !== 1'b1) $display("FAIL pre_reset_mdc: got %b, required 1", mdc_a);
    else passes++;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({mdc_a, mdio_t_a, rsp_valid_a, cmd_ready_a, mdio_o_a} !== 5'b01000)
      $display("FAIL midframe_reset: {mdc,t,valid,ready,o}=%b, required 01000",
               {mdc_a, mdio_t_a, rsp_valid_a, cmd_ready_a, mdio_o_a});
    else passes++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_txn(1'b0, 1'b0, 2'b01, 5'h1F, 5'h10, 16'h8001, 1'b1, 16'h0000, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_c22_write();
    test_c22_read();
    test_c22_read_nophy();
    test_c45();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
